multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM sequencing the RV32I datapath around a single shared memory port.

---
 rtl/multicycle_sequencer_pkg.sv | 33 +++
 rtl/multicycle_sequencer_if.sv | 34 +++
 rtl/multicycle_sequencer_instr_class_decode.sv | 26 ++
 rtl/multicycle_sequencer.sv | 118 +++++++++++
 tb/tb_multicycle_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - opcode, FSM state and op-class definitions for the multicycle sequencer
package multicycle_sequencer_pkg;

  // RV32I major opcodes handled by the sequencer
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Codes are visible on the debug state port, so they are fixed explicitly
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_R      = 3'd0,
    OP_I      = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4
  } op_class_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - sequencer <-> datapath/memory control bundle
// master: the sequencer (reads ir_q, mem_ready, stall; drives every control strobe)
// slave : the datapath/memory side (drives ir_q, mem_ready, stall; reads the strobes)
interface multicycle_sequencer_if #(
  parameter int N = 32
);
  logic [N-1:0] ir_q;
  logic         mem_ready;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic         mem_sel_data;
  logic         ir_we;
  logic         pc_we;
  logic         branch_en;
  logic [1:0]   alu_op;
  logic         alu_src;
  logic         reg_we;
  logic         mem_to_reg;
  logic         illegal;
  logic [2:0]   state;

  modport master (
    input  ir_q, mem_ready, stall,
    output mem_req, mem_we, mem_sel_data, ir_we, pc_we, branch_en,
           alu_op, alu_src, reg_we, mem_to_reg, illegal, state
  );

  modport slave (
    output ir_q, mem_ready, stall,
    input  mem_req, mem_we, mem_sel_data, ir_we, pc_we, branch_en,
           alu_op, alu_src, reg_we, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/multicycle_sequencer_instr_class_decode.sv
// rtl/multicycle_sequencer_instr_class_decode.sv - combinational opcode to op-class classifier
// opcode_i : ir_q[6:0]
// class_o  : op class (OP_R when illegal)
// legal_o  : 1 when the opcode is one of the supported classes
module multicycle_sequencer_instr_class_decode
  import multicycle_sequencer_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  class_o,
  output logic       legal_o
);

  always_comb begin
    class_o = OP_R;
    legal_o = 1'b1;
    case (opcode_i)
      OPC_R:      class_o = OP_R;
      OPC_I:      class_o = OP_I;
      OPC_LOAD:   class_o = OP_LOAD;
      OPC_STORE:  class_o = OP_STORE;
      OPC_BRANCH: class_o = OP_BRANCH;
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle RV32I control FSM around a single shared memory port
// clk : rising-edge clock
// rst : asynchronous active-low reset
// bus : master side of multicycle_sequencer_if (ir_q/mem_ready/stall in, control strobes out)
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
);

  state_e    state_q, state_d;
  op_class_e op_q, op_d;
  op_class_e dec_class;
  logic      dec_legal;

  multicycle_sequencer_instr_class_decode u_decode (
    .opcode_i (bus.ir_q[6:0]),
    .class_o  (dec_class),
    .legal_o  (dec_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      op_q    <= OP_R;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_sel_data = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.branch_en    = 1'b0;
    bus.alu_op       = ALU_ADD;
    bus.alu_src      = 1'b0;
    bus.reg_we       = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.illegal      = 1'b0;
    bus.state        = state_q;

    case (state_q)
      ST_FETCH: begin
        if (!bus.stall) begin
          bus.mem_req = 1'b1;
          // IR load and PC increment happen in the completing cycle itself
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
            state_d   = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          op_d    = dec_class;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_R:      begin bus.alu_op = ALU_FUNCT;                       state_d = ST_WB;    end
          OP_I:      begin bus.alu_op = ALU_FUNCT; bus.alu_src = 1'b1;   state_d = ST_WB;    end
          OP_LOAD,
          OP_STORE:  begin bus.alu_op = ALU_ADD;   bus.alu_src = 1'b1;   state_d = ST_MEM;   end
          OP_BRANCH: begin bus.alu_op = ALU_SUB;   bus.branch_en = 1'b1; state_d = ST_FETCH; end
          default:   state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        // Address is ALU result, so keep the address-add selection stable for the whole access
        bus.mem_req      = 1'b1;
        bus.mem_sel_data = 1'b1;
        bus.mem_we       = (op_q == OP_STORE);
        bus.alu_op       = ALU_ADD;
        bus.alu_src      = 1'b1;
        if (bus.mem_ready) state_d = (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = (op_q == OP_LOAD);
        bus.alu_op     = (op_q == OP_LOAD) ? ALU_ADD : ALU_FUNCT;
        bus.alu_src    = (op_q != OP_R);
        state_d        = ST_FETCH;
      end
      ST_TRAP: begin
        bus.illegal = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase

    // Reset forces every strobe low immediately, abandoning any access in flight
    if (!rst) begin
      bus.mem_req      = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_sel_data = 1'b0;
      bus.ir_we        = 1'b0;
      bus.pc_we        = 1'b0;
      bus.branch_en    = 1'b0;
      bus.alu_op       = ALU_ADD;
      bus.alu_src      = 1'b0;
      bus.reg_we       = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.illegal      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel_data;
    logic       ir_we;
    logic       pc_we;
    logic       branch_en;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_we;
    logic       mem_to_reg;
    logic       illegal;
  } outv_t;

  typedef struct {
    outv_t exp;
    logic  stall;
    logic  rdy;
  } item_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  outv_t act;
  outv_t exp_q[$];

  multicycle_sequencer_if #(.N(32)) bus ();

  multicycle_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign act = {bus.state, bus.mem_req, bus.mem_we, bus.mem_sel_data, bus.ir_we, bus.pc_we,
                bus.branch_en, bus.alu_op, bus.alu_src, bus.reg_we, bus.mem_to_reg, bus.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected output vector per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      outv_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t actual=%b required=%b", $time, act, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] r);
    n_checks++;
    if (a !== r) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, a, r);
    end
  endtask

  // Reference classification straight from the opcode table: 0 R,1 I,2 LOAD,3 STORE,4 BRANCH,-1 illegal
  function automatic int classify(input logic [31:0] ir);
    logic [6:0] opc;
    opc = ir[6:0];
    case (opc)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return -1;
    endcase
  endfunction

  function automatic outv_t mk(input int st);
    outv_t v;
    v = '0;
    v.state = st[2:0];
    return v;
  endfunction

  // Builds the phase-by-phase expected trace of one instruction, then drives it
  task automatic do_instr(input logic [31:0] ir, input int stall_pre, input int fw, input int mw,
                          input logic stall_body, input int trap_cycles);
    item_t tr[$];
    item_t it;
    int    c;
    c = classify(ir);
    for (int i = 0; i < stall_pre; i++) begin
      it.exp = mk(0); it.stall = 1'b1; it.rdy = 1'($urandom_range(0, 1)); tr.push_back(it);
    end
    for (int i = 0; i < fw; i++) begin
      it.exp = mk(0); it.exp.mem_req = 1'b1; it.stall = 1'b0; it.rdy = 1'b0; tr.push_back(it);
    end
    it.exp = mk(0); it.exp.mem_req = 1'b1; it.exp.ir_we = 1'b1; it.exp.pc_we = 1'b1;
    it.stall = 1'b0; it.rdy = 1'b1; tr.push_back(it);
    it.exp = mk(1); it.stall = stall_body; it.rdy = 1'($urandom_range(0, 1)); tr.push_back(it);
    if (c < 0) begin
      for (int i = 0; i < trap_cycles; i++) begin
        it.exp = mk(5); it.exp.illegal = 1'b1;
        it.stall = 1'($urandom_range(0, 1)); it.rdy = 1'($urandom_range(0, 1)); tr.push_back(it);
      end
    end else begin
      it.exp = mk(2); it.stall = stall_body; it.rdy = 1'($urandom_range(0, 1));
      case (c)
        0: begin it.exp.alu_op = 2'b10; end
        1: begin it.exp.alu_op = 2'b10; it.exp.alu_src = 1'b1; end
        2, 3: begin it.exp.alu_op = 2'b00; it.exp.alu_src = 1'b1; end
        default: begin it.exp.alu_op = 2'b01; it.exp.branch_en = 1'b1; end
      endcase
      tr.push_back(it);
      if (c == 2 || c == 3) begin
        for (int i = 0; i <= mw; i++) begin
          it.exp = mk(3); it.exp.mem_req = 1'b1; it.exp.mem_sel_data = 1'b1;
          it.exp.mem_we = (c == 3); it.exp.alu_src = 1'b1;
          it.stall = stall_body; it.rdy = (i == mw); tr.push_back(it);
        end
      end
      if (c <= 2) begin
        it.exp = mk(4); it.exp.reg_we = 1'b1; it.exp.mem_to_reg = (c == 2);
        it.exp.alu_op = (c == 2) ? 2'b00 : 2'b10; it.exp.alu_src = (c != 0);
        it.stall = stall_body; it.rdy = 1'($urandom_range(0, 1)); tr.push_back(it);
      end
    end
    foreach (tr[i]) exp_q.push_back(tr[i].exp);
    bus.ir_q = ir;
    foreach (tr[i]) begin
      bus.stall     = tr[i].stall;
      bus.mem_ready = tr[i].rdy;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] opcs [5];
    opcs[0] = 7'b0110011; opcs[1] = 7'b0010011; opcs[2] = 7'b0000011;
    opcs[3] = 7'b0100011; opcs[4] = 7'b1100011;
    return {25'($urandom), opcs[$urandom_range(0, 4)]};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b0;
    bus.ir_q      = 32'h0;
    bus.stall     = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(act), 32'h0);

    // Release, then abort a store in its MEM phase with an asynchronous reset
    rst      = 1'b1;
    bus.ir_q = 32'h0050A623;
    #1;
    check("post_reset_fetch_req", {31'h0, bus.mem_req}, 32'h1);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("store_in_mem_state", 32'(bus.state), 32'd3);
    check("store_mem_we", {31'h0, bus.mem_we}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("async_rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("async_rst_state", 32'(bus.state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_release_state", 32'(bus.state), 32'd0);
    check("rst_release_mem_req", {31'h0, bus.mem_req}, 32'h1);
    @(posedge clk); #1;

    // Directed instructions
    do_instr(32'h002081B3, 0, 0, 0, 1'b0, 0);   // add
    do_instr(32'h0080A283, 0, 0, 0, 1'b0, 0);   // lw, no wait
    do_instr(32'h0080A283, 0, 0, 3, 1'b0, 0);   // lw, 3 MEM waits
    do_instr(32'h0050A623, 0, 1, 2, 1'b0, 0);   // sw with waits
    do_instr(32'h00208863, 0, 0, 0, 1'b0, 0);   // beq
    do_instr(32'h00500093, 0, 0, 0, 1'b1, 0);   // addi with stall raised after fetch
    do_instr(32'h002081B3, 4, 0, 0, 1'b0, 0);   // held FETCH until stall drops

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      do_instr(rand_ir(), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 0);
    end

    // Unsupported opcode: trap is sticky for as long as reset stays high
    do_instr(32'hFFFFFFFF, 0, 0, 0, 1'b0, 22);

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("trap_reset_outputs", 32'(act), 32'h0);
    bus.stall     = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("trap_cleared_illegal", {31'h0, bus.illegal}, 32'h0);
    check("trap_cleared_fetch_req", {31'h0, bus.mem_req}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
